// File: rtl/fifo_pkg.sv
// Shared types and sizing for the 4-cycle-write / 1-cycle-read FIFO.
// The write engine and the top-level storage both take their widths from here.
package fifo_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int FIFO_DEPTH   = 8;
  localparam int WRITE_CYCLES = 4;

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BEAT_W = (WRITE_CYCLES > 2) ? $clog2(WRITE_CYCLES) : 1;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [PTR_W:0]        cnt_t;
  typedef logic [BEAT_W-1:0]     beat_t;

  typedef enum logic {
    IDLE,
    WRITING
  } wr_state_t;

  localparam cnt_t  DEPTH_CNT = cnt_t'(FIFO_DEPTH);
  // The commit edge is the one where the beat counter holds WRITE_CYCLES-2.
  localparam beat_t LAST_BEAT = beat_t'(WRITE_CYCLES - 2);

endpackage

// File: rtl/fifo_wr_seq.sv
// Write engine: reserves a slot on push accept, then commits the latched word
// WRITE_CYCLES-1 edges later. One write in flight at a time.
module fifo_wr_seq
  import fifo_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  push,
  input  logic  full,
  input  data_t data_in,
  output logic  accept,
  output logic  commit,
  output logic  busy,
  output data_t data
);

  wr_state_t state;
  beat_t     beat_cnt;

  // NOTE: always_comb outputs get a value on every path so no latch is inferred.
  always_comb begin
    accept = 1'b0;
    commit = 1'b0;
    if (state == IDLE) begin
      accept = push && !full;
    end else begin
      commit = (beat_cnt == LAST_BEAT);
    end
  end

  assign busy = (state == WRITING);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= WRITING;
            beat_cnt <= '0;
            data     <= data_in;
          end
        end
        WRITING: begin
          if (commit) begin
            state <= IDLE;
          end else begin
            beat_cnt <= beat_cnt + beat_t'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_4c_w_1c_r.sv
// FIFO with a WRITE_CYCLES-clock write commit and a single-cycle read.
// Define FIFO_ERR_FLAGS_EN to build sticky overflow/underflow flags.
module fifo_4c_w_1c_r
  import fifo_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_en,
  output logic                  write_en,
  output logic                  wr_busy,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  data_t mem [FIFO_DEPTH];
  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  cnt_t  committed;
  cnt_t  occupancy;
  cnt_t  committed_nxt;
  cnt_t  occupancy_nxt;

  logic  accept;
  logic  commit;
  logic  do_pop;
  data_t wr_data;

  fifo_wr_seq u_wr_seq (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .full    (full),
    .data_in (data_in),
    .accept  (accept),
    .commit  (commit),
    .busy    (wr_busy),
    .data    (wr_data)
  );

  // Occupancy counts reserved in-flight slots; committed counts readable ones.
  always_comb begin
    do_pop        = pop && !empty;
    committed_nxt = committed + cnt_t'(commit) - cnt_t'(do_pop);
    occupancy_nxt = occupancy + cnt_t'(accept) - cnt_t'(do_pop);
  end

  // NOTE: storage is not reset; pointers and counts alone define which
  // entries are valid, so clearing the array would buy nothing.
  always_ff @(posedge clock) begin
    if (commit && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      committed <= '0;
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      read_en   <= 1'b0;
      write_en  <= 1'b0;
      data_out  <= '0;
    end else begin
      write_en  <= commit;
      read_en   <= do_pop;
      committed <= committed_nxt;
      occupancy <= occupancy_nxt;
      full      <= (occupancy_nxt == DEPTH_CNT);
      empty     <= (committed_nxt == '0);
      if (commit) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (do_pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + ptr_t'(1);
      end
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !accept) begin
        overflow <= 1'b1;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_4c_w_1c_r.sv
// Self-checking bench for fifo_4c_w_1c_r: directed scenarios plus a randomized
// push/pop run, all compared against a queue-based reference model.
module tb_fifo_4c_w_1c_r;

  localparam int WC    = 4;
  localparam int DEPTH = 8;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       read_en;
  logic       write_en;
  logic       wr_busy;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;

  logic [14:0] obs;
  assign obs = {data_out, read_en, write_en, wr_busy, full, empty, overflow, underflow};

  int checks = 0;
  int errors = 0;

  fifo_4c_w_1c_r dut (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .data_in   (data_in),
    .pop       (pop),
    .data_out  (data_out),
    .read_en   (read_en),
    .write_en  (write_en),
    .wr_busy   (wr_busy),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clock = ~clock;

  // Reference model: committed words in a queue, plus at most one word in flight.
  logic [7:0] m_q[$];
  bit         m_busy;
  int         m_age;
  logic [7:0] m_wdata;
  logic [7:0] m_dout;
  bit         m_ren;
  bit         m_wen;
  bit         m_ovf;
  bit         m_unf;
  bit         m_took;

  function automatic void model_update();
    bit was_empty;
    bit was_full;
    bit was_busy;
    m_took = 1'b0;
    if (reset) begin
      m_q.delete();
      m_busy = 1'b0;
      m_age  = 0;
      m_dout = 8'h00;
      m_ren  = 1'b0;
      m_wen  = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      was_empty = (m_q.size() == 0);
      was_full  = ((m_q.size() + int'(m_busy)) == DEPTH);
      was_busy  = m_busy;
      m_ren = 1'b0;
      m_wen = 1'b0;
      if (pop && !was_empty) begin
        m_dout = m_q.pop_front();
        m_ren  = 1'b1;
      end
      if (m_busy) begin
        m_age++;
        if (m_age == WC - 1) begin
          m_q.push_back(m_wdata);
          m_busy = 1'b0;
          m_wen  = 1'b1;
        end
      end
      m_took = push && !was_full && !was_busy;
      if (m_took) begin
        m_busy  = 1'b1;
        m_age   = 0;
        m_wdata = data_in;
      end
      if (FLAGS_ON && push && !m_took) m_ovf = 1'b1;
      if (FLAGS_ON && pop && was_empty) m_unf = 1'b1;
    end
  endfunction

  function automatic logic [14:0] exp_vec();
    int occ;
    occ = m_q.size() + int'(m_busy);
    return {m_dout, m_ren, m_wen, m_busy, occ == DEPTH, m_q.size() == 0, m_ovf, m_unf};
  endfunction

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = 8'h00;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({empty, full, read_en, write_en, wr_busy, overflow, underflow} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_state: got e%b f%b re%b we%b b%b o%b u%b, want e1 f0 re0 we0 b0 o0 u0",
               empty, full, read_en, write_en, wr_busy, overflow, underflow);
    end
    reset = 1'b0;
    step();
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL reset_release: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_single();
    push = 1'b1; data_in = 8'd5;
    step();
    push = 1'b0;
    checks++;
    if (wr_busy !== 1'b1 || empty !== 1'b1) begin
      errors++; $display("FAIL single_accept: got busy=%b empty=%b want busy=1 empty=1", wr_busy, empty);
    end
    for (int e = 1; e < WC; e++) begin
      step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL single_beat%0d: got %h want %h", e, obs, exp_vec());
      end
    end
    checks++;
    if (write_en !== 1'b1 || wr_busy !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL single_commit: got we=%b busy=%b empty=%b want we=1 busy=0 empty=0",
               write_en, wr_busy, empty);
    end
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++;
    if (read_en !== 1'b1 || data_out !== 8'd5 || empty !== 1'b1) begin
      errors++;
      $display("FAIL single_pop: got re=%b data=%0d empty=%b want re=1 data=5 empty=1",
               read_en, data_out, empty);
    end
  endtask

  task automatic test_fill();
    for (int v = 1; v <= DEPTH; v++) begin
      push = 1'b1; data_in = 8'(v);
      step();
      push = 1'b0;
      checks++;
      if (wr_busy !== 1'b1 || obs !== exp_vec()) begin
        errors++; $display("FAIL fill_accept%0d: got %h want %h", v, obs, exp_vec());
      end
      if (v == DEPTH) begin
        checks++;
        if (full !== 1'b1) begin
          errors++; $display("FAIL fill_full: got full=%b want 1", full);
        end
      end
      for (int e = 1; e < WC; e++) step();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL fill_commit%0d: got %h want %h", v, obs, exp_vec());
      end
    end
    push = 1'b1; data_in = 8'd9;
    step();
    push = 1'b0;
    checks++;
    if (wr_busy !== 1'b0 || full !== 1'b1 || overflow !== FLAGS_ON) begin
      errors++;
      $display("FAIL fill_ninth: got busy=%b full=%b ovf=%b want busy=0 full=1 ovf=%b",
               wr_busy, full, overflow, FLAGS_ON);
    end
    pop = 1'b1;
    for (int v = 1; v <= DEPTH; v++) begin
      step();
      checks++;
      if (read_en !== 1'b1 || data_out !== 8'(v) || obs !== exp_vec()) begin
        errors++; $display("FAIL fill_pop%0d: got re=%b data=%0d want re=1 data=%0d", v, read_en, data_out, v);
      end
    end
    pop = 1'b0;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL fill_drained: got empty=%b full=%b want empty=1 full=0", empty, full);
    end
  endtask

  task automatic test_busy_push();
    int wen_count = 0;
    push = 1'b1;
    data_in = 8'hA1; step(); wen_count += int'(write_en);
    data_in = 8'hB2; step(); wen_count += int'(write_en);
    data_in = 8'hC3; step(); wen_count += int'(write_en);
    push = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      wen_count += int'(write_en);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL busy_cycle%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (wen_count != 1) begin
      errors++; $display("FAIL busy_commits: got %0d write_en pulses want 1", wen_count);
    end
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++;
    if (read_en !== 1'b1 || data_out !== 8'hA1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL busy_pop: got re=%b data=%h empty=%b want re=1 data=a1 empty=1", read_en, data_out, empty);
    end
  endtask

  task automatic test_underflow();
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++;
    if (read_en !== 1'b0 || data_out !== 8'hA1 || empty !== 1'b1 || underflow !== FLAGS_ON) begin
      errors++;
      $display("FAIL underflow: got re=%b data=%h empty=%b unf=%b want re=0 data=a1 empty=1 unf=%b",
               read_en, data_out, empty, underflow, FLAGS_ON);
    end
    step();
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL underflow_hold: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_reset_abort();
    bit saw_wen = 1'b0;
    push = 1'b1; data_in = 8'd7;
    step();
    push = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      saw_wen |= write_en;
    end
    checks++;
    if (saw_wen || empty !== 1'b1 || wr_busy !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got we_seen=%b empty=%b busy=%b ovf=%b unf=%b want 0 1 0 0 0",
               saw_wen, empty, wr_busy, overflow, underflow);
    end
  endtask

  task automatic test_wrap_random();
    int next_push = 1;
    int next_pop  = 1;
    int cyc       = 0;
    while (next_pop <= 20 && cyc < 800) begin
      push    = (next_push <= 20) && ($urandom_range(0, 3) != 0);
      data_in = 8'(next_push);
      pop     = ($urandom_range(0, 1) == 1);
      step();
      cyc++;
      if (m_took) next_push++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL wrap_cycle%0d: got %h want %h", cyc, obs, exp_vec());
      end
      if (m_ren) begin
        checks++;
        if (data_out !== 8'(next_pop)) begin
          errors++; $display("FAIL wrap_order: got %0d want %0d", data_out, next_pop);
        end
        next_pop++;
      end
    end
    push = 1'b0; pop = 1'b0;
    checks++;
    if (next_pop <= 20) begin
      errors++; $display("FAIL wrap_timeout: got %0d words popped want 20", next_pop - 1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_busy_push();
    test_underflow();
    test_reset_abort();
    test_wrap_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
